// File: rtl/rx_seq_pkg.sv
// Shared definitions for the RX sequencer: state encoding, control-word bit
// positions and default schedule lengths.
package rx_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FLUSH   = 3'd1,
        ST_AGC     = 3'd2,
        ST_SEARCH  = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_HOLDOFF = 3'd5
    } state_t;

    localparam int CTRL_START     = 0;
    localparam int CTRL_AGC_EN_N  = 1;
    localparam int CTRL_SEARCH_EN = 2;

    localparam int DEF_FLUSH_LEN   = 16;
    localparam int DEF_AGC_LEN     = 256;
    localparam int DEF_PAY_LEN     = 10000;
    localparam int DEF_HOLDOFF_LEN = 100;
    localparam int DEF_TIMEOUT_LEN = 4096;
    localparam int DEF_CNT_W       = 16;

endpackage

// File: rtl/rx_seq_cnt.sv
// Per-state event counter: cleared on state entry, advanced on each qualifying
// event, flags when the count has reached len_m1.
module rx_seq_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] len_m1,
    output logic             term
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + CNT_W'(1);
    end

    assign term = (cnt == len_m1);

endmodule

// File: rtl/rx_seq_ctrl.sv
// RX chain sequencer: flush, AGC settle, preamble search, capture, hold-off.
// Optional search timeout enabled by defining RX_SEQ_TIMEOUT_EN.
module rx_seq_ctrl
    import rx_seq_pkg::*;
#(
    parameter int FLUSH_LEN   = DEF_FLUSH_LEN,
    parameter int AGC_LEN     = DEF_AGC_LEN,
    parameter int PAY_LEN     = DEF_PAY_LEN,
    parameter int HOLDOFF_LEN = DEF_HOLDOFF_LEN,
    parameter int TIMEOUT_LEN = DEF_TIMEOUT_LEN,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_en,
    input  logic        i_agc_en_n,
    input  logic        i_vld,
    input  logic        i_frame_det,
    output logic        o_rx_rst,
    output logic [31:0] o_ctrl,
    output logic        o_store_en,
    output logic        o_busy,
    output logic [2:0]  o_state,
    output logic [15:0] o_frame_cnt,
    output logic [15:0] o_timeout_cnt
);

    state_t           state, nxt;
    logic [CNT_W-1:0] len_m1;
    logic             ev, term, done, clr, capt_done;
    logic [31:0]      ctrl_d;
`ifdef RX_SEQ_TIMEOUT_EN
    logic             tmo;
`endif

    // FLUSH is timed in clocks; every other state is timed in sample strobes
    assign ev   = (state == ST_FLUSH) | i_vld;
    assign done = term & ev;
    assign clr  = (nxt != state) | (state == ST_IDLE);

    always_comb begin
        len_m1 = '0;
        case (state)
            ST_FLUSH:   len_m1 = CNT_W'(FLUSH_LEN - 1);
            ST_AGC:     len_m1 = CNT_W'(AGC_LEN - 1);
            ST_SEARCH:  len_m1 = CNT_W'(TIMEOUT_LEN - 1);
            ST_CAPTURE: len_m1 = CNT_W'(PAY_LEN - 1);
            ST_HOLDOFF: len_m1 = CNT_W'(HOLDOFF_LEN - 1);
            default:    len_m1 = '0;
        endcase
    end

    rx_seq_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk    (i_clk),
        .rst_n  (i_rstn),
        .clr    (clr),
        .en     (ev),
        .len_m1 (len_m1),
        .term   (term)
    );

    // State register, plus output registers decoded from the next state
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state       <= ST_IDLE;
            o_ctrl      <= '0;
            o_rx_rst    <= 1'b0;
            o_store_en  <= 1'b0;
            o_busy      <= 1'b0;
            o_frame_cnt <= '0;
        end else begin
            state       <= nxt;
            o_ctrl      <= ctrl_d;
            o_rx_rst    <= (nxt == ST_FLUSH);
            o_store_en  <= (nxt == ST_CAPTURE);
            o_busy      <= (nxt != ST_IDLE);
            o_frame_cnt <= o_frame_cnt + 16'(capt_done);
        end
    end

    always_comb begin
        nxt       = state;
        capt_done = 1'b0;
`ifdef RX_SEQ_TIMEOUT_EN
        tmo       = 1'b0;
`endif
        case (state)
            ST_IDLE:    nxt = ST_FLUSH;
            ST_FLUSH:   if (done) nxt = i_agc_en_n ? ST_SEARCH : ST_AGC;
            ST_AGC:     if (done) nxt = ST_SEARCH;
            ST_SEARCH: begin
                if (i_frame_det)
                    nxt = ST_CAPTURE;
`ifdef RX_SEQ_TIMEOUT_EN
                else if (done) begin
                    nxt = i_agc_en_n ? ST_FLUSH : ST_AGC;
                    tmo = 1'b1;
                end
`endif
            end
            ST_CAPTURE: begin
                if (done) begin
                    nxt       = ST_HOLDOFF;
                    capt_done = 1'b1;
                end
            end
            ST_HOLDOFF: if (done) nxt = ST_SEARCH;
            default:    nxt = ST_IDLE;
        endcase
        // Disarm overrides everything, including a capture completing this cycle
        if (!i_en) begin
            nxt       = ST_IDLE;
            capt_done = 1'b0;
`ifdef RX_SEQ_TIMEOUT_EN
            tmo       = 1'b0;
`endif
        end
    end

    always_comb begin
        ctrl_d                 = '0;
        ctrl_d[CTRL_START]     = nxt inside {ST_AGC, ST_SEARCH, ST_CAPTURE, ST_HOLDOFF};
        ctrl_d[CTRL_AGC_EN_N]  = (nxt inside {ST_CAPTURE, ST_HOLDOFF}) |
                                 ((nxt inside {ST_AGC, ST_SEARCH}) & i_agc_en_n);
        ctrl_d[CTRL_SEARCH_EN] = (nxt == ST_SEARCH);
    end

    assign o_state = state;

`ifdef RX_SEQ_TIMEOUT_EN
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn)
            o_timeout_cnt <= '0;
        else if (tmo)
            o_timeout_cnt <= o_timeout_cnt + 16'd1;
    end
`else
    assign o_timeout_cnt = '0;
`endif

endmodule

// File: tb/tb_rx_seq_ctrl.sv
// Self-checking bench for rx_seq_ctrl: directed scenarios plus randomized
// stimulus against an event-countdown reference model.
module tb_rx_seq_ctrl;

    localparam int FLUSH_LEN   = 4;
    localparam int AGC_LEN     = 8;
    localparam int PAY_LEN     = 20;
    localparam int HOLDOFF_LEN = 5;
    localparam int TIMEOUT_LEN = 30;

    localparam int S_IDLE = 0, S_FLUSH = 1, S_AGC = 2, S_SEARCH = 3, S_CAPTURE = 4, S_HOLDOFF = 5;

    logic        clk, rstn, en_s, agc_s, vld_s, det_s;
    logic        o_rx_rst, o_store_en, o_busy;
    logic [31:0] o_ctrl;
    logic [2:0]  o_state;
    logic [15:0] o_frame_cnt, o_timeout_cnt;

    int errs = 0;
    int checks = 0;
    int cyc = 0;
    logic last_vld = 1'b0;

    // reference model: state plus qualifying events still required to leave it
    int          m_state, m_left;
    logic [15:0] m_frames, m_tmos;
    logic        m_agc;

    rx_seq_ctrl #(
        .FLUSH_LEN(FLUSH_LEN), .AGC_LEN(AGC_LEN), .PAY_LEN(PAY_LEN),
        .HOLDOFF_LEN(HOLDOFF_LEN), .TIMEOUT_LEN(TIMEOUT_LEN), .CNT_W(16)
    ) dut (
        .i_clk(clk), .i_rstn(rstn), .i_en(en_s), .i_agc_en_n(agc_s),
        .i_vld(vld_s), .i_frame_det(det_s),
        .o_rx_rst(o_rx_rst), .o_ctrl(o_ctrl), .o_store_en(o_store_en),
        .o_busy(o_busy), .o_state(o_state), .o_frame_cnt(o_frame_cnt),
        .o_timeout_cnt(o_timeout_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
        $fatal(1, "watchdog");
    end

    function automatic int len_of(input int s);
        case (s)
            S_FLUSH:   return FLUSH_LEN;
            S_AGC:     return AGC_LEN;
            S_SEARCH:  return TIMEOUT_LEN;
            S_CAPTURE: return PAY_LEN;
            S_HOLDOFF: return HOLDOFF_LEN;
            default:   return 0;
        endcase
    endfunction

    task automatic enter(input int s);
        m_state = s;
        m_left  = len_of(s);
    endtask

    task automatic model_reset();
        m_state = S_IDLE; m_left = 0; m_frames = 0; m_tmos = 0; m_agc = 1'b0;
    endtask

    task automatic model_step(input logic en, input logic agc_n, input logic vld, input logic det);
        m_agc = agc_n;
        if (!en) begin
            m_state = S_IDLE;
            return;
        end
        case (m_state)
            S_IDLE: enter(S_FLUSH);
            S_FLUSH: begin
                m_left--;
                if (m_left == 0) enter(agc_n ? S_SEARCH : S_AGC);
            end
            S_AGC: if (vld) begin
                m_left--;
                if (m_left == 0) enter(S_SEARCH);
            end
            S_SEARCH: begin
                if (det) enter(S_CAPTURE);
`ifdef RX_SEQ_TIMEOUT_EN
                else if (vld) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_tmos++;
                        enter(agc_n ? S_FLUSH : S_AGC);
                    end
                end
`endif
            end
            S_CAPTURE: if (vld) begin
                m_left--;
                if (m_left == 0) begin
                    m_frames++;
                    enter(S_HOLDOFF);
                end
            end
            S_HOLDOFF: if (vld) begin
                m_left--;
                if (m_left == 0) enter(S_SEARCH);
            end
            default: m_state = S_IDLE;
        endcase
    endtask

    function automatic logic [69:0] exp_vec();
        logic [31:0] c;
        logic        start, frz;
        start = (m_state >= S_AGC);
        frz   = (m_state == S_CAPTURE || m_state == S_HOLDOFF) ||
                ((m_state == S_AGC || m_state == S_SEARCH) && m_agc);
        c = {29'd0, m_state == S_SEARCH, frz, start};
        return {3'(m_state), c, m_state == S_FLUSH, m_state == S_CAPTURE,
                m_state != S_IDLE, m_frames, m_tmos};
    endfunction

    function automatic logic [69:0] dut_vec();
        return {o_state, o_ctrl, o_rx_rst, o_store_en, o_busy, o_frame_cnt, o_timeout_cnt};
    endfunction

    task automatic tick(input logic det, input logic vld);
        det_s = det;
        vld_s = vld;
        @(posedge clk);
        model_step(en_s, agc_s, vld, det);
        #1;
        last_vld = vld;
    endtask

    // one clock with the periodic 1-in-8 sample strobe
    task automatic step(input logic det);
        logic v;
        v = (cyc % 8 == 7);
        cyc++;
        tick(det, v);
    endtask

    task automatic test_reset();
        rstn = 1'b0; en_s = 1'b0; agc_s = 1'b0; vld_s = 1'b0; det_s = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (o_state !== 3'd0) begin errs++; $display("FAIL reset_state got=%0d exp=0", o_state); end
        checks++; if (o_ctrl !== 32'h0) begin errs++; $display("FAIL reset_ctrl got=%h exp=0", o_ctrl); end
        checks++; if ({o_rx_rst, o_store_en, o_busy} !== 3'b000) begin errs++; $display("FAIL reset_flags got=%b exp=000", {o_rx_rst, o_store_en, o_busy}); end
        checks++; if ({o_frame_cnt, o_timeout_cnt} !== 32'h0) begin errs++; $display("FAIL reset_cnts got=%h exp=0", {o_frame_cnt, o_timeout_cnt}); end
        rstn = 1'b1;
    endtask

    task automatic test_arm();
        int n, s;
        en_s = 1'b1; agc_s = 1'b0;
        step(0);
        checks++; if ({o_state, o_rx_rst} !== {3'd1, 1'b1}) begin errs++; $display("FAIL arm_flush got state=%0d rx_rst=%b exp 1/1", o_state, o_rx_rst); end
        n = 1;
        for (int i = 0; i < 50 && o_rx_rst; i++) begin
            step(0);
            if (o_rx_rst) n++;
        end
        checks++; if (n != FLUSH_LEN) begin errs++; $display("FAIL arm_flush_len got=%0d exp=%0d", n, FLUSH_LEN); end
        checks++; if ({o_state, o_ctrl} !== {3'd2, 32'h1}) begin errs++; $display("FAIL arm_agc got state=%0d ctrl=%h exp 2/1", o_state, o_ctrl); end
        n = 0;
        for (int i = 0; i < 400 && o_state == 3'd2; i++) begin
            s = o_state;
            step(0);
            if (s == S_AGC && last_vld) n++;
        end
        checks++; if (n != AGC_LEN) begin errs++; $display("FAIL arm_agc_len got=%0d exp=%0d", n, AGC_LEN); end
        checks++; if ({o_state, o_ctrl} !== {3'd3, 32'h5}) begin errs++; $display("FAIL arm_search got state=%0d ctrl=%h exp 3/5", o_state, o_ctrl); end
    endtask

    task automatic test_capture();
        int n, s;
        step(1);
        checks++; if ({o_state, o_store_en, o_ctrl} !== {3'd4, 1'b1, 32'h3}) begin errs++; $display("FAIL cap_entry got state=%0d store=%b ctrl=%h exp 4/1/3", o_state, o_store_en, o_ctrl); end
        n = 0;
        for (int i = 0; i < 1000 && o_state == 3'd4; i++) begin
            s = o_state;
            step(0);
            if (s == S_CAPTURE && last_vld) n++;
        end
        checks++; if (n != PAY_LEN) begin errs++; $display("FAIL cap_len got=%0d exp=%0d", n, PAY_LEN); end
        checks++; if ({o_state, o_store_en, o_frame_cnt} !== {3'd5, 1'b0, 16'd1}) begin errs++; $display("FAIL cap_holdoff got state=%0d store=%b frames=%0d exp 5/0/1", o_state, o_store_en, o_frame_cnt); end
        // detect pulses during HOLDOFF must not restart a capture
        n = 0;
        for (int i = 0; i < 400 && o_state == 3'd5; i++) begin
            s = o_state;
            step(i[0]);
            if (s == S_HOLDOFF && last_vld) n++;
        end
        checks++; if (n != HOLDOFF_LEN) begin errs++; $display("FAIL holdoff_len got=%0d exp=%0d", n, HOLDOFF_LEN); end
        checks++; if ({o_state, o_frame_cnt} !== {3'd3, 16'd1}) begin errs++; $display("FAIL holdoff_exit got state=%0d frames=%0d exp 3/1", o_state, o_frame_cnt); end
    endtask

    task automatic test_ignored_detect();
        int n, s;
        en_s = 1'b0; step(0);
        en_s = 1'b1; agc_s = 1'b0;
        for (int i = 0; i < 50 && o_state != 3'd2; i++) step(0);
        n = 0;
        for (int i = 0; i < 400 && o_state == 3'd2; i++) begin
            s = o_state;
            step(i[0]);
            if (s == S_AGC && last_vld) n++;
            if (o_state == 3'd4) break;
        end
        checks++; if (n != AGC_LEN) begin errs++; $display("FAIL agc_det_len got=%0d exp=%0d", n, AGC_LEN); end
        checks++; if ({o_state, o_frame_cnt} !== {3'd3, 16'd1}) begin errs++; $display("FAIL agc_det_exit got state=%0d frames=%0d exp 3/1", o_state, o_frame_cnt); end
    endtask

    task automatic test_agc_bypass();
        logic saw_agc;
        en_s = 1'b0; step(0);
        checks++; if ({o_state, o_busy} !== {3'd0, 1'b0}) begin errs++; $display("FAIL disarm got state=%0d busy=%b exp 0/0", o_state, o_busy); end
        agc_s = 1'b1; en_s = 1'b1;
        saw_agc = 1'b0;
        for (int i = 0; i < 50 && o_state != 3'd3; i++) begin
            step(0);
            if (o_state == 3'd2) saw_agc = 1'b1;
        end
        checks++; if (saw_agc !== 1'b0) begin errs++; $display("FAIL bypass_agc_visited got=%b exp=0", saw_agc); end
        checks++; if ({o_state, o_ctrl} !== {3'd3, 32'h7}) begin errs++; $display("FAIL bypass_search got state=%0d ctrl=%h exp 3/7", o_state, o_ctrl); end
    endtask

    task automatic test_abort();
        int n, s;
        step(1);
        n = 0;
        for (int i = 0; i < 400 && n < 10; i++) begin
            s = o_state;
            step(0);
            if (s == S_CAPTURE && last_vld) n++;
        end
        checks++; if (o_state !== 3'd4) begin errs++; $display("FAIL abort_pre got state=%0d exp 4", o_state); end
        en_s = 1'b0;
        step(0);
        checks++; if ({o_state, o_ctrl} !== {3'd0, 32'h0}) begin errs++; $display("FAIL abort_idle got state=%0d ctrl=%h exp 0/0", o_state, o_ctrl); end
        checks++; if ({o_rx_rst, o_store_en, o_busy} !== 3'b000) begin errs++; $display("FAIL abort_flags got=%b exp=000", {o_rx_rst, o_store_en, o_busy}); end
        checks++; if (o_frame_cnt !== 16'd1) begin errs++; $display("FAIL abort_frames got=%0d exp=1", o_frame_cnt); end
    endtask

    task automatic test_timeout();
        int n, s;
        en_s = 1'b1; agc_s = 1'b0;
        for (int i = 0; i < 400 && o_state != 3'd3; i++) step(0);
`ifdef RX_SEQ_TIMEOUT_EN
        n = 0;
        for (int i = 0; i < 1000 && o_state == 3'd3; i++) begin
            s = o_state;
            step(0);
            if (s == S_SEARCH && last_vld) n++;
        end
        checks++; if (n != TIMEOUT_LEN) begin errs++; $display("FAIL tmo_len got=%0d exp=%0d", n, TIMEOUT_LEN); end
        checks++; if ({o_state, o_timeout_cnt} !== {3'd2, 16'd1}) begin errs++; $display("FAIL tmo_exit got state=%0d tmos=%0d exp 2/1", o_state, o_timeout_cnt); end
        for (int i = 0; i < 400 && o_state != 3'd3; i++) step(0);
        n = 0;
        for (int i = 0; i < 1000 && n < TIMEOUT_LEN - 1; i++) begin
            s = o_state;
            step(0);
            if (s == S_SEARCH && last_vld) n++;
        end
        for (int i = 0; i < 8 && (cyc % 8) != 7; i++) step(0);
        step(1);
        checks++; if ({o_state, o_timeout_cnt} !== {3'd4, 16'd1}) begin errs++; $display("FAIL tmo_det_wins got state=%0d tmos=%0d exp 4/1", o_state, o_timeout_cnt); end
`else
        for (int i = 0; i < 8 * (TIMEOUT_LEN + 10); i++) step(0);
        checks++; if ({o_state, o_timeout_cnt} !== {3'd3, 16'd0}) begin errs++; $display("FAIL no_tmo got state=%0d tmos=%0d exp 3/0", o_state, o_timeout_cnt); end
`endif
    endtask

    task automatic test_random();
        logic v, d;
        for (int i = 0; i < 4000; i++) begin
            if (en_s && $urandom_range(299) == 0) en_s = 1'b0;
            else if (!en_s && $urandom_range(3) == 0) begin
                en_s  = 1'b1;
                agc_s = 1'($urandom_range(1));
            end
            v = ($urandom_range(7) == 0);
            d = ($urandom_range(29) == 0);
            tick(d, v);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errs++;
                $display("FAIL random cyc=%0d got=%h exp=%h", i, dut_vec(), exp_vec());
                break;
            end
        end
    endtask

    initial begin
        test_reset();
        test_arm();
        test_capture();
        test_ignored_detect();
        test_agc_bypass();
        test_abort();
        test_timeout();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
